// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage bus between the pipeline and the hazard scoreboard.
// Ports (slave view): i_opcode, i_reg_num_1/2, i_rd_num, i_valid, i_adv, i_flush in;
//                     stall, o_fwd_sel_1/2, o_stall_cnt out.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       i_opcode;
    logic [4:0]       i_reg_num_1;
    logic [4:0]       i_reg_num_2;
    logic [4:0]       i_rd_num;
    logic             i_valid;
    logic             i_adv;
    logic             i_flush;
    logic             stall;
    logic [3:0]       o_fwd_sel_1;
    logic [3:0]       o_fwd_sel_2;
    logic [CNT_W-1:0] o_stall_cnt;

    modport master (
        output i_opcode, i_reg_num_1, i_reg_num_2, i_rd_num, i_valid, i_adv, i_flush,
        input  stall, o_fwd_sel_1, o_fwd_sel_2, o_stall_cnt
    );

    modport slave (
        input  i_opcode, i_reg_num_1, i_reg_num_2, i_rd_num, i_valid, i_adv, i_flush,
        output stall, o_fwd_sel_1, o_fwd_sel_2, o_stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW hazard detection, stall and forwarding-select generation for an in-order pipeline.
// Ports: i_clk, i_rst_n (asynchronous, active-low);
//        bus (slave): decode opcode/rs1/rs2/rd, i_valid, i_adv, i_flush in;
//                     stall, o_fwd_sel_1/2 (0 = regfile, k = slot k-1), o_stall_cnt out.
module hazard_scoreboard #(
    parameter int DEPTH    = 3,
    parameter int FWD_EN   = 0,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input logic                i_clk,
    input logic                i_rst_n,
    hazard_scoreboard_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [DEPTH-1:0] vld_q, vld_d, ld_q, ld_d;
    logic [4:0]       rd_q [DEPTH];
    logic [4:0]       rd_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             use1, use2, writes, late, blk1, blk2, stall, issue;
    logic [3:0]       sel1, sel2;

    assign use1   = bus.i_opcode inside {OP_JALR, OP_BRANCH, OP_OPIMM, OP_OP, OP_LOAD, OP_STORE};
    assign use2   = bus.i_opcode inside {OP_BRANCH, OP_OP, OP_STORE};
    assign writes = bus.i_opcode inside {OP_OP, OP_OPIMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    // Branch/JALR resolve in ID/EX, so they need producer data one slot earlier.
    assign late   = bus.i_opcode inside {OP_BRANCH, OP_JALR};

    always_comb begin
        sel1 = '0;
        sel2 = '0;
        blk1 = 1'b0;
        blk2 = 1'b0;
        // Oldest slot first so the youngest match overwrites.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use1 && bus.i_reg_num_1 != '0 && vld_q[k] && rd_q[k] == bus.i_reg_num_1) begin
                sel1 = 4'(k + 1);
                blk1 = (FWD_EN == 0) || (k < ((ld_q[k] ? LOAD_LAT : 0) + (late ? 1 : 0)));
            end
            if (use2 && bus.i_reg_num_2 != '0 && vld_q[k] && rd_q[k] == bus.i_reg_num_2) begin
                sel2 = 4'(k + 1);
                blk2 = (FWD_EN == 0) || (k < ((ld_q[k] ? LOAD_LAT : 0) + (late ? 1 : 0)));
            end
        end
    end

    assign stall = bus.i_valid && !bus.i_flush && (blk1 || blk2);
    // rd=x0 producers are never tracked.
    assign issue = bus.i_valid && !bus.i_flush && !stall && writes && bus.i_rd_num != '0;

    always_comb begin
        vld_d = vld_q;
        ld_d  = ld_q;
        rd_d  = rd_q;
        if (bus.i_adv) begin
            vld_d[0] = issue;
            ld_d[0]  = bus.i_opcode == OP_LOAD;
            rd_d[0]  = bus.i_rd_num;
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
                ld_d[k]  = ld_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
        end
        cnt_d = (stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            ld_q  <= '0;
            rd_q  <= '{default: '0};
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            ld_q  <= ld_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.o_fwd_sel_1 = sel1;
    assign bus.o_fwd_sel_2 = sel2;
    assign bus.o_stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic against a queue-based model,
// run on a stall-only instance (b0) and a forwarding instance with a 3-bit counter (b1).
module tb_hazard_scoreboard;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam int         LL     = 2;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } slot_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = OP;
    logic [4:0] r1 = '0, r2 = '0, rd = '0;
    logic       vld = 1'b0, adv = 1'b0, fl = 1'b0;
    int         errs = 0;
    int         checks = 0;
    slot_t      q0[$], q1[$];

    hazard_scoreboard_if #(.CNT_W(16)) b0();
    hazard_scoreboard_if #(.CNT_W(3))  b1();

    assign b0.i_opcode = op;  assign b1.i_opcode = op;
    assign b0.i_reg_num_1 = r1;  assign b1.i_reg_num_1 = r1;
    assign b0.i_reg_num_2 = r2;  assign b1.i_reg_num_2 = r2;
    assign b0.i_rd_num = rd;  assign b1.i_rd_num = rd;
    assign b0.i_valid = vld;  assign b1.i_valid = vld;
    assign b0.i_adv = adv;  assign b1.i_adv = adv;
    assign b0.i_flush = fl;  assign b1.i_flush = fl;

    hazard_scoreboard #(.DEPTH(3), .FWD_EN(0), .LOAD_LAT(LL), .CNT_W(16)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b0.slave)
    );
    hazard_scoreboard #(.DEPTH(3), .FWD_EN(1), .LOAD_LAT(LL), .CNT_W(3)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply decode inputs, then settle to mid-cycle where outputs are sampled.
    task automatic drive(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic v, input logic ad, input logic f);
        op = o; r1 = a; r2 = b; rd = d; vld = v; adv = ad; fl = f;
        #4;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(OP, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    // Reference: scan in-flight producers youngest-first against the decode sources.
    function automatic void predict(input bit fwd, input slot_t q[$], output logic st,
                                    output logic [3:0] s1, output logic [3:0] s2);
        bit u1, u2, bl1, bl2;
        int extra;
        u1 = op inside {JALR, BRANCH, OPIMM, OP, LOAD, STORE};
        u2 = op inside {BRANCH, OP, STORE};
        extra = (op == BRANCH || op == JALR) ? 1 : 0;
        s1 = 0; s2 = 0; bl1 = 0; bl2 = 0;
        for (int i = 0; i < q.size(); i++) begin
            int avail;
            avail = (q[i].ld ? LL : 0) + extra;
            if (s1 == 0 && u1 && r1 != 0 && q[i].v && q[i].rd == r1) begin
                s1 = 4'(i + 1);
                bl1 = !fwd || i < avail;
            end
            if (s2 == 0 && u2 && r2 != 0 && q[i].v && q[i].rd == r2) begin
                s2 = 4'(i + 1);
                bl2 = !fwd || i < avail;
            end
        end
        st = vld && !fl && (bl1 || bl2);
    endfunction

    function automatic slot_t entry(input logic st);
        slot_t e;
        e.v  = vld && !fl && !st && (op inside {OP, OPIMM, LOAD, JAL, JALR, LUI, AUIPC}) && rd != 0;
        e.rd = rd;
        e.ld = op == LOAD;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(OP, 5, 5, 5, 1'b1, 1'b1, 1'b0);
        checks++; if (b0.o_stall_cnt !== 16'd0) begin errs++; $display("FAIL reset_cnt0: got %0d want 0", b0.o_stall_cnt); end
        checks++; if (b1.o_stall_cnt !== 3'd0) begin errs++; $display("FAIL reset_cnt1: got %0d want 0", b1.o_stall_cnt); end
        checks++; if (b0.stall !== 1'b0) begin errs++; $display("FAIL reset_stall0: got %0d want 0", b0.stall); end
        checks++; if (b1.o_fwd_sel_1 !== 4'd0 || b1.o_fwd_sel_2 !== 4'd0) begin errs++; $display("FAIL reset_sel1: got %0d/%0d want 0/0", b1.o_fwd_sel_1, b1.o_fwd_sel_2); end
        tick();
        rst_n = 1'b1;
        drive(OP, 5, 5, 6, 1'b1, 1'b1, 1'b0);
        checks++; if (b0.stall !== 1'b0 || b0.o_fwd_sel_1 !== 4'd0) begin errs++; $display("FAIL post_reset: got stall=%0d sel1=%0d want 0/0", b0.stall, b0.o_fwd_sel_1); end
        tick();
    endtask

    task automatic test_raw_stall();
        do_reset();
        drive(OP, 0, 0, 5, 1'b1, 1'b1, 1'b0);
        checks++; if (b0.stall !== 1'b0) begin errs++; $display("FAIL raw_producer: got %0d want 0", b0.stall); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(OP, 5, 0, 6, 1'b1, 1'b1, 1'b0);
            checks++; if (b0.stall !== 1'b1) begin errs++; $display("FAIL raw_stall[%0d]: got %0d want 1", i, b0.stall); end
            checks++; if (b0.o_fwd_sel_1 !== 4'(i + 1)) begin errs++; $display("FAIL raw_sel0[%0d]: got %0d want %0d", i, b0.o_fwd_sel_1, i + 1); end
            checks++; if (b1.stall !== 1'b0 || b1.o_fwd_sel_1 !== 4'(i + 1)) begin errs++; $display("FAIL raw_fwd[%0d]: got stall=%0d sel1=%0d want 0/%0d", i, b1.stall, b1.o_fwd_sel_1, i + 1); end
            tick();
        end
        drive(OP, 5, 0, 6, 1'b1, 1'b1, 1'b0);
        checks++; if (b0.stall !== 1'b0) begin errs++; $display("FAIL raw_release: got %0d want 0", b0.stall); end
        checks++; if (b0.o_stall_cnt !== 16'd3) begin errs++; $display("FAIL raw_cnt: got %0d want 3", b0.o_stall_cnt); end
        tick();
        drive(OP, 6, 0, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (b0.o_fwd_sel_1 !== 4'd1) begin errs++; $display("FAIL raw_issued: got %0d want 1", b0.o_fwd_sel_1); end
        tick();
    endtask

    task automatic test_load_fwd();
        do_reset();
        drive(LOAD, 1, 0, 7, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(OP, 0, 7, 8, 1'b1, 1'b1, 1'b0);
            checks++; if (b1.stall !== 1'b1 || b1.o_fwd_sel_2 !== 4'(i + 1)) begin errs++; $display("FAIL load_stall[%0d]: got stall=%0d sel2=%0d want 1/%0d", i, b1.stall, b1.o_fwd_sel_2, i + 1); end
            tick();
        end
        drive(OP, 0, 7, 8, 1'b1, 1'b1, 1'b0);
        checks++; if (b1.stall !== 1'b0 || b1.o_fwd_sel_2 !== 4'd3) begin errs++; $display("FAIL load_fwd: got stall=%0d sel2=%0d want 0/3", b1.stall, b1.o_fwd_sel_2); end
        tick();
        drive(OP, 8, 0, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (b1.stall !== 1'b0 || b1.o_fwd_sel_1 !== 4'd1) begin errs++; $display("FAIL load_issued: got stall=%0d sel1=%0d want 0/1", b1.stall, b1.o_fwd_sel_1); end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        drive(OP, 0, 0, 9, 1'b1, 1'b1, 1'b0);
        tick();
        drive(BRANCH, 9, 0, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (b1.stall !== 1'b1 || b1.o_fwd_sel_1 !== 4'd1) begin errs++; $display("FAIL br_stall: got stall=%0d sel1=%0d want 1/1", b1.stall, b1.o_fwd_sel_1); end
        tick();
        drive(BRANCH, 9, 0, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (b1.stall !== 1'b0 || b1.o_fwd_sel_1 !== 4'd2) begin errs++; $display("FAIL br_fwd: got stall=%0d sel1=%0d want 0/2", b1.stall, b1.o_fwd_sel_1); end
        tick();
    endtask

    task automatic test_youngest();
        do_reset();
        drive(OP, 0, 0, 4, 1'b1, 1'b1, 1'b0); tick();
        drive(OP, 0, 0, 10, 1'b1, 1'b1, 1'b0); tick();
        drive(OP, 0, 0, 4, 1'b1, 1'b1, 1'b0); tick();
        drive(OP, 4, 0, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (b1.stall !== 1'b0 || b1.o_fwd_sel_1 !== 4'd1) begin errs++; $display("FAIL young_fwd: got stall=%0d sel1=%0d want 0/1", b1.stall, b1.o_fwd_sel_1); end
        checks++; if (b0.stall !== 1'b1 || b0.o_fwd_sel_1 !== 4'd1) begin errs++; $display("FAIL young_nofwd: got stall=%0d sel1=%0d want 1/1", b0.stall, b0.o_fwd_sel_1); end
        tick();
    endtask

    task automatic test_x0_store();
        do_reset();
        drive(OPIMM, 0, 0, 0, 1'b1, 1'b1, 1'b0); tick();
        drive(STORE, 0, 0, 3, 1'b1, 1'b1, 1'b0);
        checks++; if (b0.stall !== 1'b0 || b0.o_fwd_sel_1 !== 4'd0) begin errs++; $display("FAIL x0_src: got stall=%0d sel1=%0d want 0/0", b0.stall, b0.o_fwd_sel_1); end
        tick();
        drive(OP, 3, 0, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (b0.stall !== 1'b0 || b0.o_fwd_sel_1 !== 4'd0) begin errs++; $display("FAIL store_nowrite: got stall=%0d sel1=%0d want 0/0", b0.stall, b0.o_fwd_sel_1); end
        tick();
        drive(OP, 0, 0, 2, 1'b1, 1'b1, 1'b0); tick();
        drive(LUI, 2, 2, 5, 1'b1, 1'b1, 1'b0);
        checks++; if (b0.stall !== 1'b0 || b0.o_fwd_sel_1 !== 4'd0) begin errs++; $display("FAIL lui_nosrc: got stall=%0d sel1=%0d want 0/0", b0.stall, b0.o_fwd_sel_1); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        drive(OP, 0, 0, 5, 1'b1, 1'b1, 1'b0); tick();
        drive(OP, 5, 0, 6, 1'b1, 1'b1, 1'b1);
        checks++; if (b0.stall !== 1'b0 || b0.o_fwd_sel_1 !== 4'd1) begin errs++; $display("FAIL flush_stall: got stall=%0d sel1=%0d want 0/1", b0.stall, b0.o_fwd_sel_1); end
        tick();
        drive(OP, 5, 0, 6, 1'b1, 1'b1, 1'b0);
        checks++; if (b0.stall !== 1'b1 || b0.o_fwd_sel_1 !== 4'd2) begin errs++; $display("FAIL flush_bubble: got stall=%0d sel1=%0d want 1/2", b0.stall, b0.o_fwd_sel_1); end
        tick();
    endtask

    task automatic test_freeze_reset();
        do_reset();
        drive(OP, 0, 0, 5, 1'b1, 1'b1, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(OP, 5, 0, 6, 1'b1, 1'b0, 1'b0);
            checks++; if (b0.stall !== 1'b1 || b0.o_fwd_sel_1 !== 4'd1) begin errs++; $display("FAIL freeze[%0d]: got stall=%0d sel1=%0d want 1/1", i, b0.stall, b0.o_fwd_sel_1); end
            tick();
        end
        drive(OP, 5, 0, 6, 1'b1, 1'b0, 1'b0);
        checks++; if (b0.o_stall_cnt !== 16'd4) begin errs++; $display("FAIL freeze_cnt: got %0d want 4", b0.o_stall_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (b0.o_stall_cnt !== 16'd0 || b0.stall !== 1'b0 || b0.o_fwd_sel_1 !== 4'd0) begin errs++; $display("FAIL async_reset: got cnt=%0d stall=%0d sel1=%0d want 0/0/0", b0.o_stall_cnt, b0.stall, b0.o_fwd_sel_1); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_saturate();
        do_reset();
        drive(LOAD, 0, 0, 7, 1'b1, 1'b1, 1'b0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(OP, 7, 0, 0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(OP, 7, 0, 0, 1'b1, 1'b0, 1'b0);
        checks++; if (b1.o_stall_cnt !== 3'd7 || b1.stall !== 1'b1) begin errs++; $display("FAIL sat_cnt: got cnt=%0d stall=%0d want 7/1", b1.o_stall_cnt, b1.stall); end
        checks++; if (b0.o_stall_cnt !== 16'd10) begin errs++; $display("FAIL wide_cnt: got %0d want 10", b0.o_stall_cnt); end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        logic       s0, s1;
        logic [3:0] e01, e02, e11, e12;
        int         c0, c1;
        ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, 7'h7f};
        do_reset();
        q0.delete();
        q1.delete();
        c0 = 0;
        c1 = 0;
        for (int n = 0; n < 500; n++) begin
            drive(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 9) == 0);
            predict(1'b0, q0, s0, e01, e02);
            predict(1'b1, q1, s1, e11, e12);
            checks++; if (b0.stall !== s0) begin errs++; $display("FAIL rnd_stall0 @%0d: got %0d want %0d", n, b0.stall, s0); end
            checks++; if (b0.o_fwd_sel_1 !== e01) begin errs++; $display("FAIL rnd_sel1_0 @%0d: got %0d want %0d", n, b0.o_fwd_sel_1, e01); end
            checks++; if (b0.o_fwd_sel_2 !== e02) begin errs++; $display("FAIL rnd_sel2_0 @%0d: got %0d want %0d", n, b0.o_fwd_sel_2, e02); end
            checks++; if (b0.o_stall_cnt !== 16'(c0)) begin errs++; $display("FAIL rnd_cnt0 @%0d: got %0d want %0d", n, b0.o_stall_cnt, c0); end
            checks++; if (b1.stall !== s1) begin errs++; $display("FAIL rnd_stall1 @%0d: got %0d want %0d", n, b1.stall, s1); end
            checks++; if (b1.o_fwd_sel_1 !== e11) begin errs++; $display("FAIL rnd_sel1_1 @%0d: got %0d want %0d", n, b1.o_fwd_sel_1, e11); end
            checks++; if (b1.o_fwd_sel_2 !== e12) begin errs++; $display("FAIL rnd_sel2_1 @%0d: got %0d want %0d", n, b1.o_fwd_sel_2, e12); end
            checks++; if (b1.o_stall_cnt !== 3'(c1)) begin errs++; $display("FAIL rnd_cnt1 @%0d: got %0d want %0d", n, b1.o_stall_cnt, c1); end
            if (adv) begin
                q0.push_front(entry(s0));
                q1.push_front(entry(s1));
                if (q0.size() > 3) void'(q0.pop_back());
                if (q1.size() > 3) void'(q1.pop_back());
            end
            if (s0 && c0 < 65535) c0++;
            if (s1 && c1 < 7) c1++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_load_fwd();
        test_branch();
        test_youngest();
        test_x0_store();
        test_flush();
        test_freeze_reset();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3: in-flight tracking slots after decode (slot 0 = ID/EX, slot DEPTH-1 = MEM/WB); legal range 1..8.
REQ-002 Parameter FWD_EN, default 0: 0 = stall on any RAW match; 1 = forwarding mode, stall only while data is unavailable.
REQ-003 Parameter LOAD_LAT, default 2: slots a load occupies before its data can be forwarded; legal range 1..DEPTH.
REQ-004 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-005 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-007 i_opcode  input  7  opcode of the instruction in decode.
REQ-008 i_reg_num_1 / i_reg_num_2  input  5 each  rs1 / rs2 of the decode instruction.
REQ-009 i_rd_num  input  5  rd of the decode instruction.
REQ-010 i_valid  input  1  decode instruction is valid.
REQ-011 i_adv  input  1  downstream pipeline advances this cycle; 0 = pipeline frozen.
REQ-012 i_flush  input  1  kill the decode instruction this cycle; it is not issued.
REQ-013 stall  output  1  hold fetch and decode this cycle.
REQ-014 o_fwd_sel_1 / o_fwd_sel_2  output  4 each  operand source: 0 = register file; k = slot k-1.
REQ-015 o_stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-016 Each slot SHALL hold {valid, rd[4:0], is_load}.
REQ-017 rs1 SHALL be used by JALR, BRANCH, OPIMM, OP, LOAD and STORE; rs2 by BRANCH, OP and STORE only. Opcodes come from the codebase opcode defines.
REQ-018 rd SHALL be written by OP, OPIMM, LOAD, JAL, JALR, LUI and AUIPC; a slot with rd=0 SHALL be stored as invalid.
REQ-019 A source SHALL match slot k when the source is used, is nonzero, slot k is valid, and rd equals the source.
REQ-020 FWD_EN=0: stall SHALL be 1 when any used source matches any slot, and i_valid=1 and i_flush=0.
REQ-021 FWD_EN=1: each slot SHALL have an availability limit A: A = LOAD_LAT for a load, 0 otherwise; A SHALL be incremented by 1 when the consumer is BRANCH or JALR.
REQ-022 FWD_EN=1: stall SHALL be 1 when the youngest matching slot k has k < A.
REQ-023 o_fwd_sel_n SHALL equal (youngest matching slot index + 1), or 0 if there is no match. The lowest index wins; the value is driven in both modes; outputs SHALL be combinational from state and inputs.
REQ-024 When i_adv=1, slots SHALL shift: slot k+1 <= slot k, and slot DEPTH-1 is discarded.
REQ-025 On that shift, slot 0 SHALL load the decode instruction when i_valid=1, i_flush=0 and stall=0; otherwise it SHALL load a bubble (valid=0).
REQ-026 When i_adv=0, all slots SHALL hold; stall and o_fwd_sel_n are still evaluated.
REQ-027 i_flush=1 SHALL force stall=0 and insert a bubble into slot 0 when i_adv=1.
REQ-028 o_stall_cnt SHALL increment each cycle stall=1, and hold at 2^CNT_W-1.
REQ-029 Latency: an issued producer SHALL become visible to matching on the cycle after the i_adv edge that issued it.
REQ-030 Matching SHALL be identical for every slot; the register file is not bypassed internally, so a match in slot DEPTH-1 still counts.

Reset
REQ-031 While i_rst_n=0, asynchronously: all slots invalid, o_stall_cnt=0.
REQ-032 After reset with no match present: stall=0, o_fwd_sel_1=0, o_fwd_sel_2=0.
REQ-033 Reset asserted mid-stall SHALL clear the stall within the same cycle, as all slots are invalid.

Verification
REQ-034 FWD_EN=0, DEPTH=3, i_adv=1 every cycle: OP rd=5, then OP rs1=5 -> stall=1 for 3 cycles, then the consumer issues; o_stall_cnt=3.
REQ-035 FWD_EN=1, LOAD_LAT=2: LOAD rd=7, then OP rs2=7 -> stall=1 for 2 cycles, then o_fwd_sel_2=3 and the consumer issues.
REQ-036 FWD_EN=1: OP rd=9, then BRANCH rs1=9 -> 1 stall cycle, then o_fwd_sel_1=2.
REQ-037 Slot 0 rd=4 and slot 2 rd=4, then OP rs1=4, FWD_EN=1 -> o_fwd_sel_1=1 (youngest wins), stall=0.
REQ-038 Source x0, or STORE with rd field=3 followed by OP rs1=3 -> stall=0 (no write by STORE, x0 ignored).
REQ-039 Stalled with i_adv=0 for 4 cycles, then i_rst_n=0 -> slots hold during the freeze; o_stall_cnt=4 before reset, 0 immediately on reset; stall=0.
